// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: funct3 codes, FSM states,
// store strobe patterns and the alignment check.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] STRB_B = 4'b0001;
  localparam logic [3:0] STRB_H = 4'b0011;
  localparam logic [3:0] STRB_W = 4'b1111;

  // Halfwords need addr[0]=0, words (and undefined codes) need addr[1:0]=0.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic mis;
    case (f3)
      F3_B, F3_BU: mis = 1'b0;
      F3_H, F3_HU: mis = lo[0];
      default:     mis = (lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Backing-memory bus between dmem_ctrl (master) and the data RAM/bus (slave).
// Signals: mem_req_o/mem_we_o/mem_addr_o(word)/mem_wdata_o/mem_wstrb_o from the
// master; mem_rdata_i/mem_ack_i (1-cycle completion) from the slave.
interface dmem_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-3:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic [3:0]        mem_wstrb_o;
  logic [31:0]       mem_rdata_i;
  logic              mem_ack_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
    input  mem_rdata_i, mem_ack_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
    output mem_rdata_i, mem_ack_i
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane logic: store strobes + lane replication, and load
// byte/half extraction with sign/zero extension.
// Ports: funct3, addr_lo (addr[1:0]), wdata (LSB-aligned store data),
// rword (backing read word) -> strb_c, wdata_c, ldata_c.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  strb_c,
  output logic [31:0] wdata_c,
  output logic [31:0] ldata_c
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Shift the addressed lane down to bit 0; halves only use addr[1].
  assign byte_v = 8'(rword >> {addr_lo, 3'b000});
  assign half_v = 16'(rword >> {addr_lo[1], 4'b0000});

  always_comb begin
    strb_c  = STRB_W;
    wdata_c = wdata;
    ldata_c = rword;
    case (funct3)
      F3_B: begin
        strb_c  = STRB_B << addr_lo;
        wdata_c = {4{wdata[7:0]}};
        ldata_c = {{24{byte_v[7]}}, byte_v};
      end
      F3_BU: begin
        strb_c  = STRB_B << addr_lo;
        wdata_c = {4{wdata[7:0]}};
        ldata_c = {24'h0, byte_v};
      end
      F3_H: begin
        strb_c  = STRB_H << addr_lo;
        wdata_c = {2{wdata[15:0]}};
        ldata_c = {{16{half_v[15]}}, half_v};
      end
      F3_HU: begin
        strb_c  = STRB_H << addr_lo;
        wdata_c = {2{wdata[15:0]}};
        ldata_c = {16'h0, half_v};
      end
      default: begin
        strb_c  = STRB_W;
        wdata_c = wdata;
        ldata_c = rword;
      end
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory responder: turns held load/store requests into
// multi-cycle backing transfers and stalls the pipeline via busywait_o.
// Ports: clk_i, rst_i (async, active-low); mem_read_i/mem_write_i/addr_i/
// wdata_i/funct3_i request; busywait_o (combinational stall), rdata_o
// (extended load data), misalign_o / err_o pulses; mem (backing bus, master).
// Optional: define DMEM_TIMEOUT_EN to abort a transfer after TIMEOUT_CYC
// cycles without mem_ack_i; otherwise BUSY waits indefinitely and err_o = 0.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  input  logic [2:0]        funct3_i,
  output logic              busywait_o,
  output logic [31:0]       rdata_o,
  output logic              misalign_o,
  output logic              err_o,
  dmem_if.master            mem
);

  state_t            state;
  logic              req_q;
  logic              we_q;
  logic              both_q;
  logic [ADDR_W-3:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic [2:0]        f3_q;
  logic [1:0]        lo_q;
  logic              mis_seen;
  logic [ADDR_W-1:0] mis_addr;

  logic              req_c;
  logic              misal_c;
  logic [2:0]        sel_f3_c;
  logic [1:0]        sel_lo_c;
  logic [3:0]        strb_c;
  logic [31:0]       wdata_c;
  logic [31:0]       ldata_c;

  assign req_c   = mem_read_i | mem_write_i;
  assign misal_c = is_misaligned(funct3_i, addr_i[1:0]);

  // Stores are formatted from live inputs in IDLE; loads are extracted from
  // the registered access attributes when the ack arrives.
  assign sel_f3_c = (state == ST_IDLE) ? funct3_i    : f3_q;
  assign sel_lo_c = (state == ST_IDLE) ? addr_i[1:0] : lo_q;

  dmem_lane_align u_lane (
    .funct3  (sel_f3_c),
    .addr_lo (sel_lo_c),
    .wdata   (wdata_i),
    .rword   (mem.mem_rdata_i),
    .strb_c  (strb_c),
    .wdata_c (wdata_c),
    .ldata_c (ldata_c)
  );

  assign busywait_o = ((state == ST_IDLE) && req_c && !misal_c) || (state == ST_BUSY);

  assign mem.mem_req_o   = req_q;
  assign mem.mem_we_o    = we_q;
  assign mem.mem_addr_o  = addr_q;
  assign mem.mem_wdata_o = wdata_q;
  assign mem.mem_wstrb_o = wstrb_q;

`ifdef DMEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt;
`else
  assign err_o = 1'b0;
`endif

  // FSM, request registers and registered status outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= ST_IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      both_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      f3_q       <= '0;
      lo_q       <= '0;
      mis_seen   <= 1'b0;
      mis_addr   <= '0;
      rdata_o    <= '0;
      misalign_o <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
      err_o      <= 1'b0;
      cnt        <= '0;
`endif
    end else begin
      misalign_o <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
      err_o      <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (req_c) begin
            if (misal_c) begin
              // One pulse per instruction: re-arm only on a new address or request drop.
              if (!mis_seen || (addr_i != mis_addr)) begin
                misalign_o <= 1'b1;
                rdata_o    <= '0;
              end
              mis_seen <= 1'b1;
              mis_addr <= addr_i;
            end else begin
              req_q    <= 1'b1;
              we_q     <= mem_write_i;
              both_q   <= mem_read_i & mem_write_i;
              addr_q   <= addr_i[ADDR_W-1:2];
              wdata_q  <= wdata_c;
              wstrb_q  <= mem_write_i ? strb_c : 4'b0000;
              f3_q     <= funct3_i;
              lo_q     <= addr_i[1:0];
              mis_seen <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
              cnt      <= '0;
`endif
              state    <= ST_BUSY;
            end
          end else begin
            mis_seen <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (mem.mem_ack_i) begin
            req_q <= 1'b0;
            if (!we_q) begin
              rdata_o <= ldata_c;
            end else if (both_q) begin
              rdata_o <= '0;
            end
            state <= ST_DONE;
          end
`ifdef DMEM_TIMEOUT_EN
          else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            req_q   <= 1'b0;
            err_o   <= 1'b1;
            rdata_o <= '0;
            state   <= ST_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
`endif
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: hand-computed loads, stores, misalignment,
// reset during a transfer and (with DMEM_TIMEOUT_EN) the ack timeout.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned TOUT   = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd, wr;
  logic [31:0] addr, wd;
  logic [2:0]  f3;
  logic        busywait, misalign, err;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  dmem_if #(.ADDR_W(ADDR_W)) mem_bus ();

  dmem_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TOUT)) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .mem_read_i  (rd),
    .mem_write_i (wr),
    .addr_i      (addr),
    .wdata_i     (wd),
    .funct3_i    (f3),
    .busywait_o  (busywait),
    .rdata_o     (rdata),
    .misalign_o  (misalign),
    .err_o       (err),
    .mem         (mem_bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int          bw_cnt, req_cyc;
  logic [31:0] r_rdata, r_wdata;
  logic [29:0] r_addr;
  logic [3:0]  r_wstrb;
  logic        r_we, r_err, stable, done;
  logic        err_seen = 1'b0;

  always @(negedge clk) if (err === 1'b1) err_seen = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one aligned access and play the backing memory; ack_after counts
  // mem_req_o cycles (0 = never ack). Entered and left at posedge+1.
  task automatic run_txn(input string tag, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] f, input int ack_after,
                         input logic [31:0] word);
    rd = r; wr = w; addr = a; wd = d; f3 = f;
    mem_bus.mem_rdata_i = word;
    bw_cnt = 0; req_cyc = 0; done = 1'b0; stable = 1'b1; r_err = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (busywait) bw_cnt++;
      if (mem_bus.mem_req_o) begin
        req_cyc++;
        if (req_cyc == 1) begin
          r_we = mem_bus.mem_we_o; r_addr = mem_bus.mem_addr_o;
          r_wdata = mem_bus.mem_wdata_o; r_wstrb = mem_bus.mem_wstrb_o;
        end else if (r_we !== mem_bus.mem_we_o || r_addr !== mem_bus.mem_addr_o ||
                     r_wdata !== mem_bus.mem_wdata_o || r_wstrb !== mem_bus.mem_wstrb_o) begin
          stable = 1'b0;
        end
        if (req_cyc == ack_after) mem_bus.mem_ack_i = 1'b1;
      end else if (!busywait && c > 0) begin
        done = 1'b1; r_rdata = rdata; r_err = err;
      end
      @(posedge clk); #1;
      mem_bus.mem_ack_i = 1'b0;
    end
    rd = 1'b0; wr = 1'b0;
    chk({tag, "_done"}, 32'(done), 32'd1);
  endtask

  // Hold a misaligned request for n cycles, counting activity.
  task automatic hold_misaligned(input logic [31:0] a, input logic [2:0] f, input int n,
                                 output int pulses, output int reqs, output int stalls);
    rd = 1'b1; wr = 1'b0; addr = a; f3 = f;
    pulses = 0; reqs = 0; stalls = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (misalign) pulses++;
      if (mem_bus.mem_req_o) reqs++;
      if (busywait) stalls++;
      @(posedge clk); #1;
    end
  endtask

  int p1, q1, s1, p2, q2, s2;

  initial begin
    rst_n = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wd = '0; f3 = F3_W;
    mem_bus.mem_ack_i = 1'b0; mem_bus.mem_rdata_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_busywait", 32'(busywait), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_req", 32'(mem_bus.mem_req_o), 0);
    chk("rst_misalign", 32'(misalign), 0);
    chk("rst_err", 32'(err), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_txn("lw100", 1, 0, 32'h100, 0, F3_W, 3, 32'hDEADBEEF);
    chk("lw100_bw", bw_cnt, 4);
    chk("lw100_rdata", r_rdata, 32'hDEADBEEF);
    chk("lw100_we", 32'(r_we), 0);
    chk("lw100_addr", 32'(r_addr), 32'h40);
    chk("lw100_stable", 32'(stable), 1);

    run_txn("lb103", 1, 0, 32'h103, 0, F3_B, 1, 32'h80FF1234);
    chk("lb103_bw", bw_cnt, 2);
    chk("lb103_rdata", r_rdata, 32'hFFFFFF80);
    run_txn("lbu103", 1, 0, 32'h103, 0, F3_BU, 1, 32'h80FF1234);
    chk("lbu103_rdata", r_rdata, 32'h00000080);
    run_txn("lhu102", 1, 0, 32'h102, 0, F3_HU, 1, 32'h80FF1234);
    chk("lhu102_rdata", r_rdata, 32'h000080FF);
    run_txn("lh102", 1, 0, 32'h102, 0, F3_H, 2, 32'h80FF1234);
    chk("lh102_rdata", r_rdata, 32'hFFFF80FF);

    run_txn("sb101", 0, 1, 32'h101, 32'h000000AB, F3_B, 2, 32'h0);
    chk("sb101_bw", bw_cnt, 3);
    chk("sb101_wstrb", 32'(r_wstrb), 32'h2);
    chk("sb101_wdata", r_wdata, 32'hABABABAB);
    chk("sb101_we", 32'(r_we), 1);
    chk("sb101_addr", 32'(r_addr), 32'h40);
    chk("sb101_rdata_held", r_rdata, 32'hFFFF80FF);
    chk("sb101_stable", 32'(stable), 1);

    run_txn("sh106", 0, 1, 32'h106, 32'h00001234, F3_H, 1, 32'h0);
    chk("sh106_wstrb", 32'(r_wstrb), 32'hC);
    chk("sh106_wdata", r_wdata, 32'h12341234);
    chk("sh106_addr", 32'(r_addr), 32'h41);

    run_txn("sw108", 0, 1, 32'h108, 32'hCAFEBABE, 3'b011, 1, 32'h0);
    chk("sw108_wstrb", 32'(r_wstrb), 32'hF);
    chk("sw108_wdata", r_wdata, 32'hCAFEBABE);
    chk("sw108_addr", 32'(r_addr), 32'h42);

    run_txn("lw200", 1, 0, 32'h200, 0, F3_W, 1, 32'h11223344);
    chk("lw200_rdata", r_rdata, 32'h11223344);

    run_txn("rw10c", 1, 1, 32'h10C, 32'h5555AAAA, F3_W, 1, 32'h99999999);
    chk("rw10c_we", 32'(r_we), 1);
    chk("rw10c_wstrb", 32'(r_wstrb), 32'hF);
    chk("rw10c_rdata", r_rdata, 32'h0);

    run_txn("lw204", 1, 0, 32'h204, 0, F3_W, 2, 32'h55667788);
    chk("lw204_rdata", r_rdata, 32'h55667788);

    hold_misaligned(32'h102, F3_W, 4, p1, q1, s1);
    hold_misaligned(32'h101, F3_W, 3, p2, q2, s2);
    rd = 1'b0;
    @(negedge clk);
    if (misalign) p2++;
    chk("mis102_pulses", p1, 1);
    chk("mis102_req", q1, 0);
    chk("mis102_busywait", s1, 0);
    chk("mis101_pulses", p2, 1);
    chk("mis101_req", q2, 0);
    chk("mis_rdata", rdata, 32'h0);
    @(posedge clk); #1;

    // Reset in the middle of a transfer, then a stale ack.
    rd = 1'b1; addr = 32'h300; f3 = F3_W; mem_bus.mem_rdata_i = 32'hCAFEF00D;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid_req_before", 32'(mem_bus.mem_req_o), 1);
    #2;
    rst_n = 1'b0; rd = 1'b0;
    #1;
    chk("rst_mid_req_drop", 32'(mem_bus.mem_req_o), 0);
    chk("rst_mid_busywait", 32'(busywait), 0);
    @(posedge clk); #1;
    rst_n = 1'b1; mem_bus.mem_ack_i = 1'b1;
    @(posedge clk); #1;
    mem_bus.mem_ack_i = 1'b0;
    q1 = 0; s1 = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (mem_bus.mem_req_o) q1++;
      if (busywait) s1++;
    end
    chk("rst_mid_late_req", q1, 0);
    chk("rst_mid_late_bw", s1, 0);
    chk("rst_mid_rdata", rdata, 32'h0);
    @(posedge clk); #1;

    run_txn("lw500", 1, 0, 32'h500, 0, F3_W, 1, 32'h0BADF00D);
    chk("lw500_rdata", r_rdata, 32'h0BADF00D);

`ifdef DMEM_TIMEOUT_EN
    run_txn("tout", 1, 0, 32'h400, 0, F3_W, 0, 32'h12345678);
    chk("tout_bw", bw_cnt, 32'(TOUT + 1));
    chk("tout_err", 32'(r_err), 1);
    chk("tout_rdata", r_rdata, 32'h0);
    @(negedge clk);
    chk("tout_err_pulse", 32'(err), 0);
    chk("tout_req_idle", 32'(mem_bus.mem_req_o), 0);
`else
    chk("err_never", 32'(err_seen), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
